lpc_client_arbiter: RTL

// Data-provider-side controller for the LPC peripheral: decodes lpc_addr into 4 address windows, routes
// I/O read/write handshakes to the matching client, answers unmapped/timed-out reads with 8'hFF, and

---
 rtl/lpc_client_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lpc_client_arbiter.sv
// rtl/lpc_client_arbiter.sv - LPC provider-side address decoder, client request router and IRQ merger
module lpc_client_arbiter #(
  parameter logic [15:0] BASE0   = 16'h0000,
  parameter logic [15:0] BASE1   = 16'h0000,
  parameter logic [15:0] BASE2   = 16'h0000,
  parameter logic [15:0] BASE3   = 16'h0000,
  parameter logic [15:0] MASK0   = 16'h0000,
  parameter logic [15:0] MASK1   = 16'h0000,
  parameter logic [15:0] MASK2   = 16'h0000,
  parameter logic [15:0] MASK3   = 16'h0000,
  parameter logic [7:0]  TIMEOUT = 8'd64
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_wdata_i,
  input  logic        lpc_data_wr_i,
  input  logic        lpc_data_req_i,
  output logic [7:0]  lpc_rdata_o,
  output logic        lpc_data_rd_o,
  output logic        lpc_wr_done_o,
  output logic [3:0]  irq_num_o,
  output logic        interrupt_o,
  output logic [15:0] cl_addr_o,
  output logic [7:0]  cl_wdata_o,
  output logic [3:0]  cl_rd_req_o,
  output logic [3:0]  cl_wr_req_o,
  input  logic [31:0] cl_rdata_i,
  input  logic [3:0]  cl_ack_i,
  input  logic [3:0]  cl_irq_i,
  input  logic [15:0] cl_irq_vec_i,
  output logic        timeout_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_DONE, S_WR_WAIT, S_WR_DONE} state_t;

  localparam logic [3:0][15:0] C_BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [3:0][15:0] C_MASK = {MASK3, MASK2, MASK1, MASK0};

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_d;
  logic        r_wr_d;
  logic [7:0]  r_timer;
  logic [1:0]  r_sel;
  logic [1:0]  r_owner;
  logic        w_hit;
  logic [1:0]  w_hit_idx;
  logic [1:0]  w_irq_low;
  logic        w_rd_edge;
  logic        w_wr_edge;
  logic        w_ack;
  logic        w_tmo;
  logic [7:0]  w_timer_inc;

  assign w_rd_edge   = lpc_data_req_i & ~r_req_d;
  assign w_wr_edge   = lpc_data_wr_i & ~r_wr_d;
  assign w_ack       = cl_ack_i[r_sel];
  assign w_timer_inc = r_timer + 8'd1;
  // The timer counts completed WAIT cycles, so expiry fires on the TIMEOUT-th one
  assign w_tmo       = (TIMEOUT != 8'd0) && (w_timer_inc == TIMEOUT);

  // Window decode: iterate downward so the lowest matching window wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if ((C_MASK[k] != 16'h0000) && ((lpc_addr_i & C_MASK[k]) == (C_BASE[k] & C_MASK[k]))) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(k);
      end
    end
  end

  // Lowest-numbered pending interrupt source
  always_comb begin
    w_irq_low = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (cl_irq_i[k]) w_irq_low = 2'(k);
    end
  end

  // State register and request/write edge detectors
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= S_IDLE;
      r_req_d <= 1'b0;
      r_wr_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_d <= lpc_data_req_i;
      r_wr_d  <= lpc_data_wr_i;
    end
  end

  // Next-state logic; a read edge takes precedence over a simultaneous write edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_edge)      w_state_nxt = w_hit ? S_RD_WAIT : S_RD_DONE;
        else if (w_wr_edge) w_state_nxt = w_hit ? S_WR_WAIT : S_WR_DONE;
      end
      S_RD_WAIT: begin
        if (w_ack || w_tmo)      w_state_nxt = S_RD_DONE;
        else if (!lpc_data_req_i) w_state_nxt = S_IDLE;
      end
      S_RD_DONE: if (!lpc_data_req_i) w_state_nxt = S_IDLE;
      S_WR_WAIT: begin
        if (w_ack || w_tmo)     w_state_nxt = S_WR_DONE;
        else if (!lpc_data_wr_i) w_state_nxt = S_IDLE;
      end
      S_WR_DONE: if (!lpc_data_wr_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs toward peripheral and clients, plus the WAIT timer
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lpc_rdata_o   <= 8'h00;
      lpc_data_rd_o <= 1'b0;
      lpc_wr_done_o <= 1'b0;
      cl_addr_o     <= 16'h0000;
      cl_wdata_o    <= 8'h00;
      cl_rd_req_o   <= 4'h0;
      cl_wr_req_o   <= 4'h0;
      timeout_o     <= 1'b0;
      r_timer       <= 8'd0;
      r_sel         <= 2'd0;
    end else begin
      timeout_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rd_edge) begin
            cl_addr_o <= lpc_addr_i;
            if (w_hit) begin
              cl_rd_req_o <= 4'b0001 << w_hit_idx;
              r_sel       <= w_hit_idx;
              r_timer     <= 8'd0;
            end else begin
              lpc_rdata_o   <= 8'hFF;
              lpc_data_rd_o <= 1'b1;
            end
          end else if (w_wr_edge) begin
            cl_addr_o  <= lpc_addr_i;
            cl_wdata_o <= lpc_wdata_i;
            if (w_hit) begin
              cl_wr_req_o <= 4'b0001 << w_hit_idx;
              r_sel       <= w_hit_idx;
              r_timer     <= 8'd0;
            end else begin
              lpc_wr_done_o <= 1'b1;
            end
          end
        end
        S_RD_WAIT: begin
          if (w_ack) begin
            lpc_rdata_o   <= cl_rdata_i[{r_sel, 3'b000} +: 8];
            lpc_data_rd_o <= 1'b1;
            cl_rd_req_o   <= 4'h0;
          end else if (w_tmo) begin
            lpc_rdata_o   <= 8'hFF;
            lpc_data_rd_o <= 1'b1;
            cl_rd_req_o   <= 4'h0;
            timeout_o     <= 1'b1;
          end else if (!lpc_data_req_i) begin
            cl_rd_req_o <= 4'h0;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_RD_DONE: if (!lpc_data_req_i) lpc_data_rd_o <= 1'b0;
        S_WR_WAIT: begin
          if (w_ack || w_tmo) begin
            lpc_wr_done_o <= 1'b1;
            cl_wr_req_o   <= 4'h0;
            timeout_o     <= ~w_ack;
          end else if (!lpc_data_wr_i) begin
            cl_wr_req_o <= 4'h0;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_WR_DONE: if (!lpc_data_wr_i) lpc_wr_done_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // Interrupt merge: current owner keeps the slot while pending, otherwise lowest pending takes over
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      interrupt_o <= 1'b0;
      irq_num_o   <= 4'h0;
      r_owner     <= 2'd0;
    end else begin
      interrupt_o <= |cl_irq_i;
      if (cl_irq_i[r_owner]) begin
        irq_num_o <= cl_irq_vec_i[{r_owner, 2'b00} +: 4];
      end else if (|cl_irq_i) begin
        r_owner   <= w_irq_low;
        irq_num_o <= cl_irq_vec_i[{w_irq_low, 2'b00} +: 4];
      end
    end
  end

endmodule
